// File: rtl/frq_pkg.sv
// -----------------------------------------------------------------------------
// frq_pkg
// Shared definitions for the frequency-select divider and the code meter.
// Both ends derive periods from period_of(), so the code-to-period mapping
// stays identical on the transmit and receive sides.
//   NUM_CODES : number of select codes (32)
//   CODE_W    : width of a select code
//   CNT_W     : width of the period counter
//   MC_W      : width of the consecutive-match counter
//   state_e   : meter FSM states
// -----------------------------------------------------------------------------
package frq_pkg;

    localparam int NUM_CODES = 32;
    localparam int CODE_W    = 5;
    localparam int CNT_W     = 8;
    localparam int MC_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Period in clk cycles produced by select code k: P(k) = 2*(k+1).
    function automatic logic [CNT_W-1:0] period_of(input logic [CODE_W-1:0] code);
        logic [CNT_W-1:0] ext;
        ext       = {3'b000, code};
        period_of = (ext + 8'd1) << 1;
    endfunction

    // Absolute difference of two counter values.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        abs_diff = d;
    endfunction

endpackage

// File: rtl/frq_edge_sync.sv
// -----------------------------------------------------------------------------
// frq_edge_sync
// Brings the asynchronous measured signal into the clk domain with a 2-FF
// synchronizer and produces a one-cycle pulse on each synchronized rising
// edge using one further delay FF. The pulse is consumed at the third clk
// edge after the input rises; that latency is constant and cancels out of
// edge-to-edge period measurements.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (clears the synchronizer)
//   sig_i    in  asynchronous input signal
//   rise_o   out one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module frq_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Synchronizer chain and edge-detect delay stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    // Both operands are flops, so the pulse is glitch-free.
    assign rise_o = sync2_q & ~dly_q;

endmodule

// File: rtl/frq_code_meter.sv
// -----------------------------------------------------------------------------
// frq_code_meter
// Measures the period of sig_in in clk cycles, decodes it to the 5-bit
// frequency-select code that produced it and reports lock / error /
// loss-of-signal status. All outputs are registered.
// Parameters:
//   TOL        allowed |measured - P(k)| for a match
//   LOCK_COUNT consecutive identical matches needed to lock (1..15)
//   TIMEOUT    cycles without a rising edge before signal loss (< 255)
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   sig_in     in  asynchronous measured signal
//   code_out   out decoded code, holds last locked value
//   code_valid out one-cycle pulse per matched measurement while locked
//   locked     out decoded code is stable
//   err        out one-cycle pulse when a period matches no code
//   no_signal  out no rising edge seen within TIMEOUT cycles
// -----------------------------------------------------------------------------
module frq_code_meter
    import frq_pkg::*;
#(
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sig_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    output logic              locked,
    output logic              err,
    output logic              no_signal
);

    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [MC_W-1:0]  MC_MAX    = {MC_W{1'b1}};

    logic                  rise_s;
    logic [NUM_CODES-1:0]  hit_s;
    logic                  match_found_s;
    logic [CODE_W-1:0]     match_code_s;
    logic [MC_W-1:0]       mc_inc_s;

    state_e                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [MC_W-1:0]       match_cnt_q,  match_cnt_d;
    logic [CODE_W-1:0]     last_code_q,  last_code_d;
    logic [CODE_W-1:0]     code_out_q,   code_out_d;
    logic                  code_valid_q, code_valid_d;
    logic                  locked_q,     locked_d;
    logic                  err_q,        err_d;
    logic                  no_signal_q,  no_signal_d;

    frq_edge_sync u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (sig_in),
        .rise_o  (rise_s)
    );

    // Decode ROM: flag every code within tolerance, then pick the lowest.
    always_comb begin
        hit_s        = '0;
        match_code_s = '0;
        for (int k = 0; k < NUM_CODES; k++) begin
            hit_s[k] = (abs_diff(cnt_q, period_of(CODE_W'(k))) <= TOL_C);
        end
        // Descending scan so the lowest matching code is written last.
        for (int k = NUM_CODES - 1; k >= 0; k--) begin
            match_code_s = hit_s[k] ? CODE_W'(k) : match_code_s;
        end
        match_found_s = |hit_s;
    end

    // Next-state, counter and output logic of the measurement FSM.
    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt_q;
        last_code_d  = last_code_q;
        code_out_d   = code_out_q;
        code_valid_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;
        no_signal_d  = no_signal_q;
        mc_inc_s     = (match_cnt_q == MC_MAX) ? match_cnt_q : (match_cnt_q + 4'd1);

        // cnt restarts at 1 on every edge so its value at the next edge is the period.
        if (rise_s) begin
            cnt_d = 8'd1;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                // First edge only starts the period counter.
                if (rise_s) begin
                    no_signal_d = 1'b0;
                    match_cnt_d = 4'd0;
                    state_d     = MEASURE;
                end else begin
                    state_d     = IDLE;
                end
            end

            MEASURE: begin
                if (rise_s) begin
                    if (!match_found_s) begin
                        err_d       = 1'b1;
                        match_cnt_d = 4'd0;
                    end else if (match_code_s == last_code_q) begin
                        match_cnt_d = mc_inc_s;
                    end else begin
                        last_code_d = match_code_s;
                        match_cnt_d = 4'd1;
                    end
                    if (match_found_s && (match_cnt_d >= LOCK_C)) begin
                        state_d      = LOCKED;
                        locked_d     = 1'b1;
                        code_out_d   = last_code_d;
                        code_valid_d = 1'b1;
                    end else begin
                        state_d      = MEASURE;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    no_signal_d = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = 4'd0;
                    state_d     = IDLE;
                end else begin
                    state_d     = MEASURE;
                end
            end

            LOCKED: begin
                if (rise_s) begin
                    if (match_found_s && (match_code_s == code_out_q)) begin
                        code_valid_d = 1'b1;
                    end else if (match_found_s) begin
                        locked_d     = 1'b0;
                        last_code_d  = match_code_s;
                        match_cnt_d  = 4'd1;
                        state_d      = MEASURE;
                    end else begin
                        err_d        = 1'b1;
                        locked_d     = 1'b0;
                        match_cnt_d  = 4'd0;
                        state_d      = MEASURE;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    no_signal_d = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = 4'd0;
                    state_d     = IDLE;
                end else begin
                    state_d     = LOCKED;
                end
            end

            default: begin
                state_d     = IDLE;
                locked_d    = 1'b0;
                no_signal_d = 1'b1;
                match_cnt_d = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            match_cnt_q  <= 4'd0;
            last_code_q  <= 5'd0;
            code_out_q   <= 5'd0;
            code_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            no_signal_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_cnt_q  <= match_cnt_d;
            last_code_q  <= last_code_d;
            code_out_q   <= code_out_d;
            code_valid_q <= code_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            no_signal_q  <= no_signal_d;
        end
    end

    assign code_out   = code_out_q;
    assign code_valid = code_valid_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_frq_code_meter.sv
// -----------------------------------------------------------------------------
// tb_frq_code_meter
// Directed bench for frq_code_meter. dut0 uses TOL=0, dut1 uses TOL=1; both
// see the same sig_in. sig_in changes on the falling clk edge and outputs are
// sampled on the falling edge just before any new drive.
// -----------------------------------------------------------------------------
module tb_frq_code_meter;

    logic       clk;
    logic       reset_n;
    logic       sig_in;
    logic [4:0] code0;
    logic       valid0, lock0, err0, nosig0;
    logic [4:0] code1;
    logic       valid1, lock1, err1, nosig1;

    int checks_r;
    int errors_r;
    int vcnt_r;
    int ecnt_r;
    int tmo_r;
    int lock_prev_r;
    int lock_at_tmo_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    frq_code_meter dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .code_out   (code0),
        .code_valid (valid0),
        .locked     (lock0),
        .err        (err0),
        .no_signal  (nosig0)
    );

    frq_code_meter #(.TOL(1)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .code_out   (code1),
        .code_valid (valid1),
        .locked     (lock1),
        .err        (err1),
        .no_signal  (nosig1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tally();
        if (valid0) vcnt_r++;
        if (err0)   ecnt_r++;
    endtask

    // n periods of hi cycles high then lo cycles low; rising edge first.
    task automatic run_periods(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk); tally(); sig_in = 1'b1;
            for (int c = 1; c < hi; c++) begin
                @(negedge clk); tally();
            end
            @(negedge clk); tally(); sig_in = 1'b0;
            for (int c = 1; c < lo; c++) begin
                @(negedge clk); tally();
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks_r = 0; errors_r = 0; vcnt_r = 0; ecnt_r = 0;
        reset_n  = 1'b0;
        sig_in   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_val("rst_code0",  code0,  0);
        check_val("rst_valid0", valid0, 0);
        check_val("rst_lock0",  lock0,  0);
        check_val("rst_err0",   err0,   0);
        check_val("rst_nosig0", nosig0, 1);
        check_val("rst_code1",  code1,  0);
        check_val("rst_valid1", valid1, 0);
        check_val("rst_lock1",  lock1,  0);
        check_val("rst_err1",   err1,   0);
        check_val("rst_nosig1", nosig1, 1);
        reset_n = 1'b1;

        // Scenario 1: period 12 locks on code 5 after the 5th edge
        run_periods(6, 6, 1);
        check_val("s1_nosig_fall", nosig0, 0);
        check_val("s1_nolock_e1", lock0, 0);
        run_periods(6, 6, 3);
        check_val("s1_nolock_e4", lock0, 0);
        vcnt_r = 0;
        run_periods(6, 6, 1);
        check_val("s1_lock_e5", lock0, 1);
        check_val("s1_code", code0, 5);
        check_val("s1_valid_at_lock", vcnt_r, 1);
        vcnt_r = 0; ecnt_r = 0;
        run_periods(6, 6, 4);
        check_val("s1_valid_per_period", vcnt_r, 4);
        check_val("s1_no_err", ecnt_r, 0);

        // Scenario 3: switch to period 42, relock on code 20
        vcnt_r = 0;
        run_periods(21, 21, 1);
        check_val("s3_still_locked", lock0, 1);
        check_val("s3_last_valid", vcnt_r, 1);
        run_periods(21, 21, 1);
        check_val("s3_lock_drop", lock0, 0);
        check_val("s3_code_hold", code0, 5);
        run_periods(21, 21, 2);
        check_val("s3_unlocked_e4", lock0, 0);
        check_val("s3_code_unlocked", code0, 5);
        run_periods(21, 21, 1);
        check_val("s3_relock", lock0, 1);
        check_val("s3_code20", code0, 20);

        // Scenario 4: stop toggling; timeout 203 negedges after the drive
        tmo_r = 0; lock_prev_r = 0; lock_at_tmo_r = 0;
        @(negedge clk); sig_in = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 6) sig_in = 1'b0;
            if (nosig0 && (tmo_r == 0)) begin
                tmo_r         = k;
                lock_at_tmo_r = lock0;
            end
            if (tmo_r == 0) lock_prev_r = lock0;
        end
        check_val("s4_timeout_cycle", tmo_r, 203);
        check_val("s4_locked_before", lock_prev_r, 1);
        check_val("s4_locked_after", lock_at_tmo_r, 0);
        run_periods(6, 6, 1);
        check_val("s4_nosig_clear", nosig0, 0);
        run_periods(6, 6, 3);
        check_val("s4_nolock_e4", lock0, 0);
        run_periods(6, 6, 1);
        check_val("s4_relock", lock0, 1);
        check_val("s4_code5", code0, 5);

        // Scenario 2: boundary periods 2 and 64, unmatched 70 and 13
        run_periods(1, 1, 10);
        check_val("s2_p2_lock", lock0, 1);
        check_val("s2_p2_code", code0, 0);
        run_periods(32, 32, 6);
        check_val("s2_p64_lock", lock0, 1);
        check_val("s2_p64_code", code0, 31);
        ecnt_r = 0;
        run_periods(35, 35, 6);
        check_val("s2_p70_errs", ecnt_r, 5);
        check_val("s2_p70_unlock", lock0, 0);
        ecnt_r = 0;
        run_periods(7, 6, 6);
        check_val("s2_p13_errs", ecnt_r, 6);
        check_val("s2_p13_unlock", lock0, 0);

        // Scenario 5: TOL=1 instance decodes period 13 to the lowest code, 5
        check_val("s5_tol1_lock", lock1, 1);
        check_val("s5_tol1_code", code1, 5);

        // Scenario 6: async reset mid-lock, then full relock
        run_periods(6, 6, 6);
        check_val("s6_locked", lock0, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_val("s6_rst_code", code0, 0);
        check_val("s6_rst_lock", lock0, 0);
        check_val("s6_rst_nosig", nosig0, 1);
        check_val("s6_rst_valid", valid0, 0);
        check_val("s6_rst_err", err0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_periods(6, 6, 4);
        check_val("s6_nolock_e4", lock0, 0);
        run_periods(6, 6, 1);
        check_val("s6_relock", lock0, 1);
        check_val("s6_code5", code0, 5);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/frq_code_meter.md
Name: frq_code_meter

Overview:
- Measures the period of an incoming divided clock `sig_in` in `clk` cycles and decodes it back to the 5-bit frequency-select code that produced it.
- It is the receive-side counterpart of the ROM-controlled frequency divider, which turns code k into an output period of P(k) clk cycles.
- Reports the decoded code once lock is reached, plus error and loss-of-signal status.
- Sits on the ui_in/uio pins of the same tile, for loopback of `clk_out` or measurement of an external divider.

Parameters:
- TOL, 0: allowed |measured − P(k)| in clk cycles for a match.
- LOCK_COUNT, 4: consecutive identical matched measurements required before `locked` asserts (range 1..15).
- TIMEOUT, 200: clk cycles without a `sig_in` rising edge before signal loss is declared (must be < 255).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sig_in  in  1  asynchronous measured signal; any duty cycle.
- code_out  out  5  decoded select code; holds its last locked value.
- code_valid  out  1  one-cycle pulse per matched measurement while locked.
- locked  out  1  level; decoded code is stable.
- err  out  1  one-cycle pulse when a measured period matches no code.
- no_signal  out  1  level; no edge seen within TIMEOUT cycles.

Behaviour:
- Reset (async assert, sync release): code_out=0, code_valid=0, locked=0, err=0, no_signal=1, state=IDLE, counters=0, last_code=0.
- Synchronizer: 2-FF synchronizer plus one delay FF. The rise pulse fires 3 clk after a sig_in rising edge. This latency is constant, so the measured period is unaffected.
- Period counter cnt (8-bit):
  - Increments every cycle and saturates at 255.
  - On a rise pulse, cnt loads 1, so the value sampled at an edge equals the number of clk cycles between consecutive rising edges.
- Code ROM (package function): P(k) = 2·(k+1) for k = 0..31, giving periods 2..64.
  - Match rule: lowest k with |period − P(k)| ≤ TOL.
  - The comparison is combinational on the sampled period.
- State machine:
  - IDLE:
    - On a rise pulse: cnt ← 1, no_signal ← 0, match_cnt ← 0, go to MEASURE.
    - No measurement is taken on this first edge.
  - MEASURE, on a rise pulse with period = cnt:
    - No match: err pulse, match_cnt ← 0, stay.
    - Match k equal to last_code: match_cnt increments (saturating).
    - Match k different from last_code: last_code ← k, match_cnt ← 1.
    - When match_cnt reaches LOCK_COUNT: go to LOCKED, locked=1, code_out=last_code, and code_valid pulses in the same cycle as locked rises.
  - LOCKED, on a rise pulse:
    - Match k equal to code_out: code_valid pulse.
    - Match k different from code_out: locked ← 0, last_code ← k, match_cnt ← 1, go to MEASURE.
    - No match: err pulse, locked ← 0, match_cnt ← 0, go to MEASURE.
- Timeout:
  - In MEASURE or LOCKED, cnt reaching TIMEOUT without an edge sets no_signal=1, locked=0, match_cnt=0, and returns to IDLE.
  - If an edge and cnt==TIMEOUT occur in the same cycle, the edge wins.
- Output registering: all outputs are registered, one cycle after the rise pulse is evaluated.
- code_out is unchanged on lock loss; consumers gate it with locked.
- Reset mid-operation: immediate return to reset values. The synchronizer is also cleared.

Decomposition:
- Package frq_pkg holds:
  - NUM_CODES=32, CODE_W=5, CNT_W=8.
  - Function period_of(code) returning P(k).
  - State enum {IDLE, MEASURE, LOCKED}.
- The divider and this meter share period_of, so the two ends cannot drift apart.
- One sub-module, frq_edge_sync: the 2-FF synchronizer plus rising-edge pulse, with clk/reset_n.
- Decode loop and FSM live in frq_code_meter.

Test Plan:
1. Reset, drive sig_in with period 12 (6 high / 6 low), TOL=0 → no_signal falls after the first edge. locked=1 and code_out=5 after the 5th rising edge (4 matches). code_valid then pulses every 12 clk.
2. Boundaries: period 2 → code_out=0; period 64 → code_out=31. Period 70 and period 13 (TOL=0) → err pulse on every edge, locked stays 0.
3. While locked on code 5, switch to period 42 → locked drops on the first 42-cycle measurement. Relock with code_out=20 after 3 further edges. code_out reads 5 while unlocked.
4. While locked, stop toggling → no_signal=1 and locked=0 exactly when cnt hits 200 after the last edge. Resume → relock per scenario 1.
5. TOL=1, period 13 → code_out=5, the lowest matching k, after lock.
6. Assert reset_n low mid-lock, asynchronously between clk edges → all outputs go to reset values immediately, no_signal=1. After release, full relock is required.
